monopix_conf_ctrl: RTL and testbench
====================================

Name: monopix_conf_ctrl

Overview:
FPGA-side sequencer for the MONOPIX serial configuration port. Fetches a CONF_WIDTH-bit configuration image from a byte-wide synchronous RAM and shifts it MSB-first into the chip over CLK_CONF/SI_CONF. It then pulses LD_CONF and manages DEF_CONF. Sits between the register/RAM bus block and the chip pads; replaces bench-driven pad toggling.

Parameters:
CONF_WIDTH, 4096, configuration chain length in bits; must be a multiple of 8 (elaboration error otherwise)
CLK_DIV, 4, CLK cycles per conf-clock half-period; minimum 2
ADDR_W, $clog2(CONF_WIDTH/8), RAM byte address width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
START  in  1  single-cycle request to program the chip
DEF_REQ  in  1  single-cycle request to re-assert DEF_CONF
RD_ADDR  out  ADDR_W  RAM byte address
RD_EN  out  1  RAM read enable; data valid on RD_DATA the following cycle
RD_DATA  in  8  RAM read data
BUSY  out  1  high from START acceptance until DONE
DONE  out  1  one-cycle pulse at end of sequence
CLK_CONF  out  1  gated configuration clock to pad
SI_CONF  out  1  serial data to pad
LD_CONF  out  1  load strobe to pad
DEF_CONF  out  1  default-configuration select to pad
SO_CONF  in  1  serial data from pad (used only with the optional feature)

Behaviour:
- Reset values: RD_ADDR=0, RD_EN=0, BUSY=0, DONE=0, CLK_CONF=0, SI_CONF=0, LD_CONF=0, DEF_CONF=1. Reset mid-sequence aborts immediately to these values; no partial LD_CONF.
- FSM: IDLE -> FETCH -> SHIFT -> GAP -> LOAD -> FIN -> IDLE.
- IDLE: START moves to FETCH and sets BUSY. START while BUSY is ignored.
- FETCH, 2 cycles: RD_EN with RD_ADDR=0; the byte is latched into the shift register on the second cycle.
- SHIFT: one bit period = 2*CLK_DIV CLK cycles; CLK_CONF low for the first CLK_DIV, high for the second. SI_CONF updates at the start of each low phase. Bit order: byte 0 bit 7 first, which is conf bit CONF_WIDTH-1. Exactly CONF_WIDTH rising CLK_CONF edges are produced.
- Prefetch: in the first CLK cycle of bit 0 of byte n, RD_EN is issued for byte n+1, except on the last byte. The latched byte is loaded when bit 7 of it becomes due, so CLK_CONF stays uniform with no stretched phases. RD_ADDR wraps to 0 after the last byte.
- GAP: 2*CLK_DIV cycles, CLK_CONF held 0, SI_CONF holds the last bit.
- LOAD: LD_CONF=1 for 2*CLK_DIV cycles, CLK_CONF=0.
- FIN: DONE=1 for one cycle and BUSY drops in the same cycle.
- Latency: DONE asserts 2 + (CONF_WIDTH+2)*2*CLK_DIV + 1 cycles after the START sampling edge.
- DEF_CONF: cleared in the FIN cycle of the first completed sequence. Set to 1 by DEF_REQ, but only when not BUSY; otherwise the request is ignored. DEF_REQ and START in the same IDLE cycle: both take effect, and DEF_CONF clears again at FIN.
- All pad outputs are registered; no combinational path from input to pad.

Optional Feature:
MONOPIX_CONF_READBACK_EN: adds outputs RB_DATA[7:0] and RB_VALID.
- SO_CONF is sampled on each CLK_CONF rising edge during SHIFT and packed MSB-first.
- Each byte is presented on RB_DATA with a one-cycle RB_VALID pulse after its 8th sample, giving CONF_WIDTH/8 pulses per sequence. This returns the chip's previous image.
- Without the macro: SO_CONF is unused, there are no RB ports, and behaviour is otherwise identical.

Test Plan:
- CONF_WIDTH=16, CLK_DIV=2, RAM={0xA5,0x3C}, START -> SI_CONF at the 16 CLK_CONF rising edges = 1010010100111100. LD_CONF high 4 cycles. DONE exactly 75 cycles after START. DEF_CONF 1->0 at DONE.
- Same config; a START pulse 10 cycles after the first -> ignored; exactly 16 CLK_CONF edges and one DONE.
- RST asserted during SHIFT bit 7 -> all outputs at reset values asynchronously, DEF_CONF=1. A new START after release -> a full clean sequence.
- CONF_WIDTH=32, CLK_DIV=3, RAM={0x01,0x80,0xFF,0x00} -> CLK_CONF period exactly 6 cycles throughout, including byte boundaries. RD_ADDR sequence 0,1,2,3. SI pattern matches.
- DEF_REQ while BUSY -> DEF_CONF unchanged. DEF_REQ in IDLE after programming -> DEF_CONF=1 next cycle.
- With MONOPIX_CONF_READBACK_EN: loop SO_CONF from a 16-bit model preloaded with 0xC3 0x5A, CONF_WIDTH=16 -> RB_VALID twice, RB_DATA=0xC3 then 0x5A.

Source files
------------

// File: rtl/monopix_conf_ctrl.sv
`timescale 1ns/1ps
// monopix_conf_ctrl
// Sequencer for the MONOPIX serial configuration port. On START it reads a
// CONF_WIDTH-bit image from a byte-wide synchronous RAM (byte 0 first) and
// shifts it MSB-first into the chip on CLK_CONF/SI_CONF. After a quiet gap it
// pulses LD_CONF, then pulses DONE. DEF_CONF stays high from reset until the
// first completed load. DEF_REQ re-asserts it while the block is idle.
//
// Ports:
//   CLK, RST          system clock, asynchronous active-high reset
//   START, DEF_REQ    single-cycle requests
//   RD_ADDR/RD_EN     RAM read port; RD_DATA is valid the cycle after RD_EN
//   RD_DATA           RAM read data
//   BUSY, DONE        status (DONE is a one-cycle pulse)
//   CLK_CONF, SI_CONF, LD_CONF, DEF_CONF   registered pad outputs
//   SO_CONF           serial data returned by the chip
//
// Optional build macro MONOPIX_CONF_READBACK_EN: samples SO_CONF on every
// CLK_CONF rising edge and presents each completed byte on RB_DATA with a
// one-cycle RB_VALID.
module monopix_conf_ctrl #(
    parameter int CONF_WIDTH = 4096,
    parameter int CLK_DIV    = 4,
    parameter int ADDR_W     = $clog2(CONF_WIDTH/8)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              DEF_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_EN,
    input  logic [7:0]        RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              CLK_CONF,
    output logic              SI_CONF,
    output logic              LD_CONF,
    output logic              DEF_CONF,
    input  logic              SO_CONF
`ifdef MONOPIX_CONF_READBACK_EN
    ,
    output logic [7:0]        RB_DATA,
    output logic              RB_VALID
`endif
);
    localparam int NBYTES = CONF_WIDTH / 8;
    localparam int CW     = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0]     PH_MID    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]     PH_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NBYTES - 1);

    generate
        if ((CONF_WIDTH % 8) != 0 || CONF_WIDTH < 16) begin : g_bad_width
            $error("monopix_conf_ctrl: CONF_WIDTH must be a multiple of 8 and at least 16");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("monopix_conf_ctrl: CLK_DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_GAP, S_LOAD, S_FIN
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;          // CLK cycle within a bit / gap / load period
    logic [2:0]        bit_idx, bit_n;      // bit within the current byte, 0 = MSB
    logic [ADDR_W-1:0] byte_idx, byte_n;    // byte currently being shifted
    logic [7:0]        sreg, sreg_n;        // current byte, next bit out at [7]
    logic [7:0]        nxt, nxt_n;          // prefetched following byte
    logic [ADDR_W-1:0] addr_n;
    logic              rd_en_n, busy_n, done_n, clk_n, si_n, ld_n, def_n;

`ifdef MONOPIX_CONF_READBACK_EN
    logic [7:0] rb_sreg, rb_sreg_n, rb_data_n;
    logic       rb_valid_n;
`else
    logic unused_so;
    assign unused_so = SO_CONF;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sreg     <= '0;
            nxt      <= '0;
            RD_ADDR  <= '0;
            RD_EN    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            CLK_CONF <= 1'b0;
            SI_CONF  <= 1'b0;
            LD_CONF  <= 1'b0;
            DEF_CONF <= 1'b1;
`ifdef MONOPIX_CONF_READBACK_EN
            rb_sreg  <= '0;
            RB_DATA  <= '0;
            RB_VALID <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            sreg     <= sreg_n;
            nxt      <= nxt_n;
            RD_ADDR  <= addr_n;
            RD_EN    <= rd_en_n;
            BUSY     <= busy_n;
            DONE     <= done_n;
            CLK_CONF <= clk_n;
            SI_CONF  <= si_n;
            LD_CONF  <= ld_n;
            DEF_CONF <= def_n;
`ifdef MONOPIX_CONF_READBACK_EN
            rb_sreg  <= rb_sreg_n;
            RB_DATA  <= rb_data_n;
            RB_VALID <= rb_valid_n;
`endif
        end
    end

    // Next-state logic. Every output is registered from these *_n values, so
    // the pads never see a combinational path from an input.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        sreg_n  = sreg;
        nxt_n   = nxt;
        addr_n  = RD_ADDR;
        rd_en_n = 1'b0;
        busy_n  = BUSY;
        done_n  = 1'b0;
        clk_n   = CLK_CONF;
        si_n    = SI_CONF;
        ld_n    = LD_CONF;
        def_n   = DEF_CONF;
`ifdef MONOPIX_CONF_READBACK_EN
        rb_sreg_n  = rb_sreg;
        rb_data_n  = RB_DATA;
        rb_valid_n = 1'b0;
`endif

        if (DEF_REQ && !BUSY)
            def_n = 1'b1;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_n = S_FETCH;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    rd_en_n = 1'b1;
                    addr_n  = '0;
                end
            end

            S_FETCH: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(1);
                    rd_en_n = 1'b1;
                end else begin
                    // Byte 0 is on RD_DATA now; its MSB goes straight to the pad.
                    // The read for byte 1 is issued in the first cycle of bit 0.
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                    sreg_n  = RD_DATA;
                    si_n    = RD_DATA[7];
                    clk_n   = 1'b0;
                    rd_en_n = 1'b1;
                    addr_n  = ADDR_W'(1);
                end
            end

            S_SHIFT: begin
                cnt_n = cnt + 1'b1;
                // Prefetch data arrives in the second cycle of bit 0.
                if (cnt == CW'(1) && bit_idx == 3'd0)
                    nxt_n = RD_DATA;
                if (cnt == PH_MID) begin
                    clk_n = 1'b1;
`ifdef MONOPIX_CONF_READBACK_EN
                    rb_sreg_n = {rb_sreg[6:0], SO_CONF};
                    if (bit_idx == 3'd7) begin
                        rb_data_n  = {rb_sreg[6:0], SO_CONF};
                        rb_valid_n = 1'b1;
                    end
`endif
                end
                if (cnt == PH_LAST) begin
                    cnt_n = '0;
                    clk_n = 1'b0;
                    if (bit_idx == 3'd7) begin
                        if (byte_idx == LAST_BYTE) begin
                            state_n = S_GAP;
                            addr_n  = '0;
                        end else begin
                            byte_n = byte_idx + 1'b1;
                            bit_n  = '0;
                            sreg_n = nxt;
                            si_n   = nxt[7];
                            if ((byte_idx + 1'b1) != LAST_BYTE) begin
                                rd_en_n = 1'b1;
                                addr_n  = RD_ADDR + 1'b1;
                            end
                        end
                    end else begin
                        bit_n  = bit_idx + 3'd1;
                        sreg_n = {sreg[6:0], 1'b0};
                        si_n   = sreg[6];
                    end
                end
            end

            S_GAP: begin
                cnt_n = cnt + 1'b1;
                if (cnt == PH_LAST) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                    ld_n    = 1'b1;
                end
            end

            S_LOAD: begin
                cnt_n = cnt + 1'b1;
                if (cnt == PH_LAST) begin
                    state_n = S_FIN;
                    cnt_n   = '0;
                    ld_n    = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    def_n   = 1'b0;
                end
            end

            S_FIN: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_monopix_conf_ctrl.sv
`timescale 1ns/1ps
module tb_monopix_conf_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- DUT A: CONF_WIDTH=16, CLK_DIV=2 ----------------
    logic       rst16, start16, def_req16, rd_en16, busy16, done16;
    logic       cc16, si16, ld16, def16, so16;
    logic [0:0] addr16;
    logic [7:0] rd_data16;
    logic [7:0] mem16 [2];
`ifdef MONOPIX_CONF_READBACK_EN
    logic [7:0] rbd16;
    logic       rbv16;
`endif

    monopix_conf_ctrl #(.CONF_WIDTH(16), .CLK_DIV(2)) u16 (
        .CLK(clk), .RST(rst16), .START(start16), .DEF_REQ(def_req16),
        .RD_ADDR(addr16), .RD_EN(rd_en16), .RD_DATA(rd_data16),
        .BUSY(busy16), .DONE(done16), .CLK_CONF(cc16), .SI_CONF(si16),
        .LD_CONF(ld16), .DEF_CONF(def16), .SO_CONF(so16)
`ifdef MONOPIX_CONF_READBACK_EN
        , .RB_DATA(rbd16), .RB_VALID(rbv16)
`endif
    );

    always @(posedge clk) if (rd_en16) rd_data16 <= mem16[addr16];

    // Chip model: 16-bit chain, SO is the bit about to fall off the end.
    logic [15:0] chip16 = '0;
    assign so16 = chip16[15];

    logic [31:0] cap16;
    int edges16, ld16_n, done16_n, done16_cyc, t0_16;
    always @(posedge cc16) begin
        cap16   = {cap16[30:0], si16};
        chip16  = {chip16[14:0], si16};
        edges16 = edges16 + 1;
    end
    always @(negedge clk) begin
        if (ld16) ld16_n = ld16_n + 1;
        if (done16) begin
            done16_n   = done16_n + 1;
            done16_cyc = cyc;
        end
    end
`ifdef MONOPIX_CONF_READBACK_EN
    logic [7:0] rbq [$];
    always @(negedge clk) if (rbv16) rbq.push_back(rbd16);
`endif

    // ---------------- DUT B: CONF_WIDTH=32, CLK_DIV=3 ----------------
    logic       rst32, start32, def_req32, rd_en32, busy32, done32;
    logic       cc32, si32, ld32, def32;
    logic       so32 = 1'b0;
    logic [1:0] addr32;
    logic [7:0] rd_data32;
    logic [7:0] mem32 [4];
`ifdef MONOPIX_CONF_READBACK_EN
    logic [7:0] rbd32;
    logic       rbv32;
`endif

    monopix_conf_ctrl #(.CONF_WIDTH(32), .CLK_DIV(3)) u32 (
        .CLK(clk), .RST(rst32), .START(start32), .DEF_REQ(def_req32),
        .RD_ADDR(addr32), .RD_EN(rd_en32), .RD_DATA(rd_data32),
        .BUSY(busy32), .DONE(done32), .CLK_CONF(cc32), .SI_CONF(si32),
        .LD_CONF(ld32), .DEF_CONF(def32), .SO_CONF(so32)
`ifdef MONOPIX_CONF_READBACK_EN
        , .RB_DATA(rbd32), .RB_VALID(rbv32)
`endif
    );

    always @(posedge clk) if (rd_en32) rd_data32 <= mem32[addr32];

    logic [31:0] cap32;
    int edges32, done32_n, done32_cyc, t0_32, bad_per32;
    int last_rise32 = -1;
    logic [1:0] aq [$];
    always @(posedge cc32) begin
        cap32   = {cap32[30:0], si32};
        edges32 = edges32 + 1;
        if (last_rise32 >= 0 && (cyc - last_rise32) != 6) bad_per32 = bad_per32 + 1;
        last_rise32 = cyc;
    end
    always @(negedge clk) begin
        if (done32) begin
            done32_n   = done32_n + 1;
            done32_cyc = cyc;
        end
        if (rd_en32 && (aq.size() == 0 || aq[$] != addr32)) aq.push_back(addr32);
    end

    // ---------------- helpers ----------------
    task automatic clear16();
        cap16 = '0; edges16 = 0; ld16_n = 0; done16_n = 0; done16_cyc = 0;
    endtask

    task automatic pulse_start16();
        @(negedge clk);
        start16 = 1'b1;
        t0_16   = cyc;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_done16(input string name);
        int g = 0;
        while (done16_n == 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_done_seen"}, 64'(done16_n != 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_si;
        int          exp_lat;
    } vec_t;
    vec_t tbl [4];

    initial begin
        tbl[0] = '{8'hA5, 8'h3C, 16'b1010010100111100, 75};
        tbl[1] = '{8'hFF, 8'h00, 16'b1111111100000000, 75};
        tbl[2] = '{8'h01, 8'h80, 16'b0000000110000000, 75};
        tbl[3] = '{8'h5A, 8'hC3, 16'b0101101011000011, 75};

        rst16 = 1'b1; start16 = 1'b0; def_req16 = 1'b0;
        rst32 = 1'b1; start32 = 1'b0; def_req32 = 1'b0;
        clear16();
        edges32 = 0; done32_n = 0; bad_per32 = 0; cap32 = '0;
        repeat (3) @(negedge clk);

        // Reset state: addr, rd_en, busy, done, clk_conf, si, ld, def
        chk("reset16", 64'({addr16, rd_en16, busy16, done16, cc16, si16, ld16, def16}), 64'h01);
        chk("reset32", 64'({addr32, rd_en32, busy32, done32, cc32, si32, ld32, def32}), 64'h001);
        rst16 = 1'b0; rst32 = 1'b0;
        @(negedge clk);

        // Table-driven full sequences on the 16-bit chain
        for (int i = 0; i < 4; i++) begin
            mem16[0] = tbl[i].b0;
            mem16[1] = tbl[i].b1;
            clear16();
            if (i == 0) chk("def_before_first", 64'(def16), 64'd1);
            pulse_start16();
            chk($sformatf("busy_v%0d", i), 64'(busy16), 64'd1);
            wait_done16($sformatf("v%0d", i));
            chk($sformatf("si_v%0d", i), 64'(cap16[15:0]), 64'(tbl[i].exp_si));
            chk($sformatf("edges_v%0d", i), 64'(edges16), 64'd16);
            chk($sformatf("lat_v%0d", i), 64'(done16_cyc - t0_16), 64'(tbl[i].exp_lat));
            chk($sformatf("ld_cycles_v%0d", i), 64'(ld16_n), 64'd4);
            chk($sformatf("def_after_v%0d", i), 64'(def16), 64'd0);
            chk($sformatf("busy_after_v%0d", i), 64'(busy16), 64'd0);
        end

        // Second START while busy is ignored; DEF_REQ while busy is ignored
        mem16[0] = 8'hA5; mem16[1] = 8'h3C;
        clear16();
        pulse_start16();
        repeat (9) @(negedge clk);
        chk("busy_at_respin", 64'(busy16), 64'd1);
        start16 = 1'b1;
        @(negedge clk);
        start16   = 1'b0;
        def_req16 = 1'b1;
        @(negedge clk);
        def_req16 = 1'b0;
        chk("def_req_busy", 64'(def16), 64'd0);
        wait_done16("respin");
        repeat (100) @(negedge clk);
        chk("respin_done_count", 64'(done16_n), 64'd1);
        chk("respin_edges", 64'(edges16), 64'd16);
        chk("respin_lat", 64'(done16_cyc - t0_16), 64'd75);

        // DEF_REQ and START in the same idle cycle
        clear16();
        @(negedge clk);
        def_req16 = 1'b1; start16 = 1'b1; t0_16 = cyc;
        @(negedge clk);
        def_req16 = 1'b0; start16 = 1'b0;
        chk("def_req_with_start", 64'(def16), 64'd1);
        chk("busy_with_def_req", 64'(busy16), 64'd1);
        wait_done16("defstart");
        chk("defstart_def_cleared", 64'(def16), 64'd0);
        chk("defstart_lat", 64'(done16_cyc - t0_16), 64'd75);

        // DEF_REQ alone in idle
        @(negedge clk);
        def_req16 = 1'b1;
        @(negedge clk);
        def_req16 = 1'b0;
        chk("def_req_idle", 64'(def16), 64'd1);

        // Reset in the middle of bit 7 (8th bit) of the shift
        clear16();
        pulse_start16();
        repeat (31) @(negedge clk);
        chk("busy_before_abort", 64'(busy16), 64'd1);
        rst16 = 1'b1;
        #1;
        chk("abort_outputs", 64'({addr16, rd_en16, busy16, done16, cc16, si16, ld16, def16}), 64'h01);
        @(negedge clk);
        rst16 = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_ld", 64'(ld16_n), 64'd0);
        chk("abort_no_done", 64'(done16_n), 64'd0);

        // Clean sequence after the abort
        clear16();
        pulse_start16();
        wait_done16("post_abort");
        chk("post_abort_si", 64'(cap16[15:0]), 64'hA53C);
        chk("post_abort_edges", 64'(edges16), 64'd16);
        chk("post_abort_lat", 64'(done16_cyc - t0_16), 64'd75);
        chk("post_abort_def", 64'(def16), 64'd0);

        // 32-bit chain, CLK_DIV=3: uniform period across byte boundaries
        mem32[0] = 8'h01; mem32[1] = 8'h80; mem32[2] = 8'hFF; mem32[3] = 8'h00;
        @(negedge clk);
        start32 = 1'b1;
        t0_32   = cyc;
        @(negedge clk);
        start32 = 1'b0;
        begin
            int g = 0;
            while (done32_n == 0 && g < 2000) begin
                @(negedge clk);
                g++;
            end
        end
        chk("w32_done_seen", 64'(done32_n != 0), 64'd1);
        repeat (3) @(negedge clk);
        chk("w32_si", 64'(cap32), 64'h0180FF00);
        chk("w32_edges", 64'(edges32), 64'd32);
        chk("w32_period_errors", 64'(bad_per32), 64'd0);
        chk("w32_lat", 64'(done32_cyc - t0_32), 64'd207);
        chk("w32_addr_count", 64'(aq.size()), 64'd4);
        if (aq.size() == 4)
            chk("w32_addr_seq", 64'({aq[0], aq[1], aq[2], aq[3]}), 64'h1B);
        chk("w32_addr_wrap", 64'(addr32), 64'd0);
        chk("w32_def", 64'(def32), 64'd0);

`ifdef MONOPIX_CONF_READBACK_EN
        // Readback: chip holds C3 5A from its previous image
        mem16[0] = 8'h12; mem16[1] = 8'h34;
        chip16 = 16'hC35A;
        rbq.delete();
        clear16();
        pulse_start16();
        wait_done16("readback");
        chk("rb_count", 64'(rbq.size()), 64'd2);
        if (rbq.size() == 2) begin
            chk("rb_byte0", 64'(rbq[0]), 64'hC3);
            chk("rb_byte1", 64'(rbq[1]), 64'h5A);
        end
        chk("rb_chip_loaded", 64'(chip16), 64'h1234);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
